// File: rtl/ram_prog_loader.sv
// Write-port mux ahead of the 16x8 RAM: CPU pass-through in run mode,
// streamed program image at consecutive addresses in program mode.
//
// Ports:
//   CLK, RESET       clock; synchronous active-high reset
//   PROG             program mode request
//   LD_VALID/READY   loader byte handshake, LD_DATA is the byte
//   CPU_ADDR/DIN/RI  run-mode write port from MAR/bus
//   RAM_ADDR/DIN/RI  write port driven into the RAM
//   CPU_HALT         CPU freeze while loading
//   DONE             full image written, held until PROG drops
//   LD_COUNT         bytes written in the current/last load
module ram_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PROG,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_READY,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DIN,
  input  logic              CPU_RI,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DIN,
  output logic              RAM_RI,
  output logic              CPU_HALT,
  output logic              DONE,
  output logic [ADDR_W:0]   LD_COUNT
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    WRITE,
    FULL
  } st_t;

  st_t               st;
  st_t               st_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [DATA_W-1:0] dreg;
  logic [DATA_W-1:0] dreg_nxt;
  logic              ready;
  logic              ri;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st   <= RUN;
      ptr  <= '0;
      cnt  <= '0;
      dreg <= '0;
    end else begin
      st   <= st_nxt;
      ptr  <= ptr_nxt;
      cnt  <= cnt_nxt;
      dreg <= dreg_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    ptr_nxt  = ptr;
    cnt_nxt  = cnt;
    dreg_nxt = dreg;
    ready    = 1'b0;
    ri       = 1'b0;
    addr     = ptr;
    din      = dreg;
    case (st)
      RUN: begin
        addr = CPU_ADDR;
        din  = CPU_DIN;
        ri   = CPU_RI;
        if (PROG) begin
          st_nxt  = LOAD;
          ptr_nxt = '0;
          cnt_nxt = '0;
        end
      end
      LOAD: begin
        // Dropping PROG wins over a pending byte.
        if (!PROG) begin
          st_nxt = RUN;
        end else begin
          ready = 1'b1;
          if (LD_VALID) begin
            dreg_nxt = LD_DATA;
            st_nxt   = WRITE;
          end
        end
      end
      WRITE: begin
        ri      = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (ptr == LAST) begin
          st_nxt = FULL;
        end else begin
          ptr_nxt = ptr + 1'b1;
          st_nxt  = LOAD;
        end
        // The write itself is never aborted.
        if (!PROG) st_nxt = RUN;
      end
      FULL: begin
        if (!PROG) st_nxt = RUN;
      end
      default: st_nxt = RUN;
    endcase
  end

  // Reset blocks any RAM write and any
  // handshake whose byte would be lost.
  assign RAM_RI   = ri & ~RESET;
  assign LD_READY = ready & ~RESET;
  assign RAM_ADDR = addr;
  assign RAM_DIN  = din;
  assign CPU_HALT = (st != RUN);
  assign DONE     = (st == FULL);
  assign LD_COUNT = cnt;

endmodule

// File: tb/tb_ram_prog_loader.sv
// Randomized scoreboard bench for ram_prog_loader with a
// behavioural RAM image model and write-order queue.
module tb_ram_prog_loader;

  logic       CLK;
  logic       RESET;
  logic       PROG;
  logic       LD_VALID;
  logic [7:0] LD_DATA;
  logic       LD_READY;
  logic [3:0] CPU_ADDR;
  logic [7:0] CPU_DIN;
  logic       CPU_RI;
  logic [3:0] RAM_ADDR;
  logic [7:0] RAM_DIN;
  logic       RAM_RI;
  logic       CPU_HALT;
  logic       DONE;
  logic [4:0] LD_COUNT;

  ram_prog_loader dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .PROG     (PROG),
    .LD_VALID (LD_VALID),
    .LD_DATA  (LD_DATA),
    .LD_READY (LD_READY),
    .CPU_ADDR (CPU_ADDR),
    .CPU_DIN  (CPU_DIN),
    .CPU_RI   (CPU_RI),
    .RAM_ADDR (RAM_ADDR),
    .RAM_DIN  (RAM_DIN),
    .RAM_RI   (RAM_RI),
    .CPU_HALT (CPU_HALT),
    .DONE     (DONE),
    .LD_COUNT (LD_COUNT)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem[16];
  logic [7:0] exp_mem[16];
  logic [3:0] exp_addr;
  int         n_chk;
  int         n_pass;
  int         cyc;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // The RAM the loader feeds.
  always @(posedge CLK)
    if (RAM_RI) mem[RAM_ADDR] <= RAM_DIN;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endfunction

  // Program-mode write monitor.
  always @(negedge CLK) begin
    if (RAM_RI && CPU_HALT) begin
      chk("ready_in_write", 32'(LD_READY), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(RAM_ADDR), 32'(w.a));
        chk("wr_data", 32'(RAM_DIN), 32'(w.d));
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic enter_prog;
    PROG = 1'b1;
    exp_addr = '0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input bit gaps,
                           input bit keep);
    bit done;
    done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        LD_VALID = 1'b0;
      end else begin
        LD_VALID = 1'b1;
        LD_DATA  = d;
      end
      @(negedge CLK);
      if (LD_VALID && LD_READY) begin
        exp_q.push_back('{a: exp_addr, d: d});
        exp_mem[exp_addr] = d;
        exp_addr = exp_addr + 1'b1;
        done = 1;
      end
      tick();
    end
    if (!keep) LD_VALID = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  initial begin
    int c0;
    logic [7:0] d;
    logic [7:0] old0;
    n_chk = 0;
    n_pass = 0;
    RESET = 1'b1;
    PROG = 1'b0;
    LD_VALID = 1'b0;
    LD_DATA = '0;
    CPU_ADDR = 4'd3;
    CPU_DIN = 8'h5C;
    CPU_RI = 1'b1;
    exp_addr = '0;

    // reset
    tick();
    tick();
    @(negedge CLK);
    chk("rst_ram_ri", 32'(RAM_RI), 0);
    chk("rst_ready", 32'(LD_READY), 0);
    chk("rst_halt", 32'(CPU_HALT), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_count", 32'(LD_COUNT), 0);
    tick();
    RESET = 1'b0;
    CPU_RI = 1'b0;
    tick();

    // run-mode pass-through
    CPU_ADDR = 4'd5;
    CPU_DIN = 8'hA7;
    CPU_RI = 1'b1;
    @(negedge CLK);
    chk("run_addr", 32'(RAM_ADDR), 5);
    chk("run_din", 32'(RAM_DIN), 32'h A7);
    chk("run_ri", 32'(RAM_RI), 1);
    chk("run_ready", 32'(LD_READY), 0);
    tick();
    CPU_RI = 1'b0;
    CPU_ADDR = 4'd9;
    CPU_DIN = 8'h3E;
    @(negedge CLK);
    chk("run_addr2", 32'(RAM_ADDR), 9);
    chk("run_din2", 32'(RAM_DIN), 32'h3E);
    chk("run_ri2", 32'(RAM_RI), 0);
    tick();

    // full stream, valid held high
    enter_prog();
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      send_byte(8'h10 + 8'(i), 1'b0, 1'b1);
    tick();
    @(negedge CLK);
    chk("stream_cycles", 32'(cyc - c0), 32);
    chk("full_done", 32'(DONE), 1);
    chk("full_count", 32'(LD_COUNT), 16);
    chk("full_ready", 32'(LD_READY), 0);
    chk("full_halt", 32'(CPU_HALT), 1);
    tick();
    chk("full_no_17th", 32'(RAM_RI), 0);
    LD_VALID = 1'b0;
    PROG = 1'b0;
    tick();
    @(negedge CLK);
    chk("exit_done", 32'(DONE), 0);
    chk("exit_count", 32'(LD_COUNT), 16);
    chk("exit_halt", 32'(CPU_HALT), 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("img1_%0d", i),
          32'(mem[i]), 32'h10 + 32'(i));

    // random gaps and data
    tick();
    enter_prog();
    for (int i = 0; i < 16; i++)
      send_byte(8'($urandom), 1'b1, 1'b0);
    tick();
    @(negedge CLK);
    chk("gap_done", 32'(DONE), 1);
    chk("gap_count", 32'(LD_COUNT), 16);
    PROG = 1'b0;
    tick();
    for (int i = 0; i < 16; i++)
      chk($sformatf("img2_%0d", i),
          32'(mem[i]), 32'(exp_mem[i]));

    // abort after five bytes
    enter_prog();
    for (int i = 0; i < 5; i++)
      send_byte(8'($urandom), 1'b0, 1'b0);
    PROG = 1'b0;
    tick();
    @(negedge CLK);
    chk("part_count", 32'(LD_COUNT), 5);
    chk("part_done", 32'(DONE), 0);
    chk("part_halt", 32'(CPU_HALT), 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("img3_%0d", i),
          32'(mem[i]), 32'(exp_mem[i]));

    // PROG drop beats a valid byte in LOAD
    tick();
    enter_prog();
    PROG = 1'b0;
    LD_VALID = 1'b1;
    LD_DATA = 8'hEE;
    @(negedge CLK);
    chk("drop_ready", 32'(LD_READY), 0);
    tick();
    LD_VALID = 1'b0;
    @(negedge CLK);
    chk("drop_halt", 32'(CPU_HALT), 0);
    chk("drop_count", 32'(LD_COUNT), 0);

    // re-entry restarts at address 0
    tick();
    enter_prog();
    d = 8'($urandom);
    send_byte(d, 1'b0, 1'b0);
    tick();
    PROG = 1'b0;
    tick();
    @(negedge CLK);
    chk("reent_mem0", 32'(mem[0]), 32'(d));
    chk("reent_count", 32'(LD_COUNT), 1);

    // reset during WRITE
    tick();
    old0 = mem[0];
    enter_prog();
    send_byte(~old0, 1'b0, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rstw_ram_ri", 32'(RAM_RI), 0);
    exp_q.delete();
    tick();
    RESET = 1'b0;
    PROG = 1'b0;
    @(negedge CLK);
    chk("rstw_halt", 32'(CPU_HALT), 0);
    chk("rstw_count", 32'(LD_COUNT), 0);
    chk("rstw_done", 32'(DONE), 0);
    chk("rstw_mem0", 32'(mem[0]), 32'(old0));
    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
